ls_est_ctrl: RTL

- Sequencer for the NB-IoT LS channel-estimation multiplier, one slot per run.
- Per slot, fetches the 4 NRS resource elements (port 0) from the subframe RE buffer and fetches the matching QPSK NRS sign bits from the sequence generator.
- Registers both into holding registers that drive the multiplier operands, then pulses the multiplier write enable with wr_addr 0..3.
- After the fourth write, streams the 4 stored estimates to the interpolator by driving the multiplier read address under a valid/ready handshake.

---
 rtl/ls_est_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ls_est_ctrl.sv
// LS channel-estimation sequencer: fetches 4 NRS REs plus their QPSK sign bits per slot,
// loads the multiplier operands, writes 4 estimates, then streams them out under valid/ready.
module ls_est_ctrl #(
  parameter int WIDTH_R_I = 16,
  parameter int ADDR_W    = 8,
  parameter int RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           v_shift,
  input  logic                 slot_sel,
  output logic                 busy,
  output logic                 re_rd_en,
  output logic [ADDR_W-1:0]    re_rd_addr,
  input  logic [WIDTH_R_I-1:0] re_rd_r,
  input  logic [WIDTH_R_I-1:0] re_rd_i,
  output logic                 nrs_req,
  input  logic                 nrs_vld,
  input  logic [1:0]           nrs_c,
  output logic [WIDTH_R_I-1:0] mult_rx_r,
  output logic [WIDTH_R_I-1:0] mult_rx_i,
  output logic                 mult_nrs_r,
  output logic                 mult_nrs_i,
  output logic                 mult_en,
  output logic [1:0]           mult_wr_addr,
  output logic [1:0]           mult_rd_addr,
  output logic                 est_done,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_idx
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_WRITE, S_READOUT} state_t;

  state_t                 r_state, w_next;
  logic [2:0]             r_vs;
  logic                   r_slot;
  logic [1:0]             r_idx, r_rd_idx;
  logic                   r_rx_flag, r_nrs_flag, r_est_done;
  logic [RD_LAT-1:0]      r_rd_pipe;
  logic [WIDTH_R_I-1:0]   r_rx_r, r_rx_i;
  logic                   r_nrs_r, r_nrs_i;

  logic                   w_re_rd_en, w_nrs_req, w_mult_en, w_out_valid, w_busy;
  logic                   w_rd_vld, w_nrs_xfer;
  logic [2:0]             w_vs_mod, w_vs3;
  logic [4:0]             w_off;
  logic [ADDR_W-1:0]      w_base, w_addr;

  assign w_vs_mod   = (v_shift >= 3'd6) ? v_shift - 3'd6 : v_shift;
  assign w_vs3      = (r_vs < 3'd3) ? r_vs + 3'd3 : r_vs - 3'd3;
  assign w_base     = r_slot ? ADDR_W'(144) : ADDR_W'(60);
  assign w_rd_vld   = r_rd_pipe[RD_LAT-1];
  assign w_nrs_xfer = w_nrs_req & nrs_vld;

  always_comb begin
    w_off = 5'(r_vs);
    case (r_idx)
      2'd0: w_off = 5'(r_vs);
      2'd1: w_off = 5'(r_vs) + 5'd6;
      2'd2: w_off = 5'(w_vs3) + 5'd12;
      2'd3: w_off = 5'(w_vs3) + 5'd18;
      default: w_off = 5'(r_vs);
    endcase
  end

  assign w_addr = w_base + ADDR_W'(w_off);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // nrs_req is decoded so it is already high in FETCH and falls the cycle after the transfer
  always_comb begin
    w_next      = r_state;
    w_re_rd_en  = 1'b0;
    w_nrs_req   = 1'b0;
    w_mult_en   = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_re_rd_en = 1'b1;
        w_nrs_req  = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: begin
        w_nrs_req = ~r_nrs_flag;
        if (r_rx_flag && r_nrs_flag) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_mult_en = 1'b1;
        w_next    = (r_idx == 2'd3) ? S_READOUT : S_FETCH;
      end
      S_READOUT: begin
        w_out_valid = 1'b1;
        if (out_ready && (r_rd_idx == 2'd3)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vs       <= '0;
      r_slot     <= 1'b0;
      r_idx      <= '0;
      r_rd_idx   <= '0;
      r_rx_flag  <= 1'b0;
      r_nrs_flag <= 1'b0;
      r_est_done <= 1'b0;
      r_rd_pipe  <= '0;
      r_rx_r     <= '0;
      r_rx_i     <= '0;
      r_nrs_r    <= 1'b0;
      r_nrs_i    <= 1'b0;
    end else begin
      r_rd_pipe  <= RD_LAT'({r_rd_pipe, w_re_rd_en});
      r_est_done <= (r_state == S_WRITE) && (r_idx == 2'd3);
      if (r_state == S_IDLE && start) begin
        r_vs     <= w_vs_mod;
        r_slot   <= slot_sel;
        r_idx    <= '0;
        r_rd_idx <= '0;
      end
      if (r_state == S_WRITE) begin
        r_rx_flag  <= 1'b0;
        r_nrs_flag <= 1'b0;
        if (r_idx != 2'd3) r_idx <= r_idx + 2'd1;
      end
      if (r_state == S_WAIT && w_rd_vld) begin
        r_rx_r    <= re_rd_r;
        r_rx_i    <= re_rd_i;
        r_rx_flag <= 1'b1;
      end
      if (w_nrs_xfer) begin
        r_nrs_r    <= nrs_c[1];
        r_nrs_i    <= nrs_c[0];
        r_nrs_flag <= 1'b1;
      end
      if (r_state == S_READOUT && out_ready) r_rd_idx <= r_rd_idx + 2'd1;
    end
  end

  assign busy         = w_busy;
  assign re_rd_en     = w_re_rd_en;
  assign re_rd_addr   = w_re_rd_en ? w_addr : '0;
  assign nrs_req      = w_nrs_req;
  assign mult_rx_r    = r_rx_r;
  assign mult_rx_i    = r_rx_i;
  assign mult_nrs_r   = r_nrs_r;
  assign mult_nrs_i   = r_nrs_i;
  assign mult_en      = w_mult_en;
  assign mult_wr_addr = r_idx;
  assign mult_rd_addr = r_rd_idx;
  assign est_done     = r_est_done;
  assign out_valid    = w_out_valid;
  assign out_idx      = r_rd_idx;

endmodule
